seq_detect_ctrl: RTL and testbench

- Controller that sequences the pattern-match datapath for the sequence detector.
- Captures a 10-bit target pattern from the board switches and arms detection on command.
- Shifts a serial bit stream through a window register, compares it against the pattern and reports hits.
- Sits between the switch/button inputs and the display/LED logic.

---
 rtl/seq_detect_ctrl_if.sv | 30 +++
 rtl/seq_detect_ctrl.sv | 156 +++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_ctrl_if.sv
// Control/data bundle between the switch/button front end and the
// sequence-detector controller. The master side drives the inputs; the
// slave side (the controller) drives the registered outputs.
interface seq_detect_ctrl_if #(
    parameter int N     = 10,
    parameter int CNT_W = 8
);
    logic [N-1:0]     switches;
    logic             load;
    logic             start;
    logic             stop;
    logic             bit_in;
    logic             bit_valid;
    logic             continuous;
    logic [N-1:0]     pattern;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic [1:0]       state;
    logic             done;

    modport master (
        output switches, load, start, stop, bit_in, bit_valid, continuous,
        input  pattern, match, match_count, state, done
    );

    modport slave (
        input  switches, load, start, stop, bit_in, bit_valid, continuous,
        output pattern, match, match_count, state, done
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Sequence-detector controller: captures a target pattern from the switches,
// shifts a qualified serial stream through an N-bit window once armed, and
// reports hits as a one-cycle registered pulse plus a saturating hit counter.
// All outputs come straight from flops.
module seq_detect_ctrl #(
    parameter int N     = 10,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    seq_detect_ctrl_if.slave  bus
);
    localparam int FW = $clog2(N + 1);
    localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(N);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARMED  = 2'b01,
        ST_DETECT = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    state_t           state_r,   state_nx_s;
    logic [N-1:0]     pattern_r, pattern_nx_s;
    logic [N-1:0]     window_r,  window_nx_s;
    logic [FW-1:0]    fill_r,    fill_nx_s;
    logic [CNT_W-1:0] count_r,   count_nx_s;
    logic             match_r,   match_nx_s;
    logic             done_r;
    logic [N-1:0]     shifted_s;
    logic             hit_s;

    // Saturating increment so the hit counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Window contents after accepting the current bit, and whether they hit.
    always_comb begin
        shifted_s = {window_r[N-2:0], bus.bit_in};
        hit_s     = (shifted_s == pattern_r);
    end

    // Next-state and datapath updates; stop has priority over everything.
    always_comb begin
        state_nx_s   = state_r;
        pattern_nx_s = pattern_r;
        window_nx_s  = window_r;
        fill_nx_s    = fill_r;
        count_nx_s   = count_r;
        match_nx_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.load) begin
                    pattern_nx_s = bus.switches;
                end else begin
                    pattern_nx_s = pattern_r;
                end
                if (bus.start) begin
                    state_nx_s  = ST_ARMED;
                    window_nx_s = {N{1'b0}};
                    fill_nx_s   = {FW{1'b0}};
                    count_nx_s  = {CNT_W{1'b0}};
                end else begin
                    state_nx_s  = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (bus.stop) begin
                    state_nx_s = ST_IDLE;
                end else if (bus.bit_valid) begin
                    window_nx_s = shifted_s;
                    if (fill_r == FILL_LAST) begin
                        // Window just became full: evaluate it on this same edge.
                        fill_nx_s  = FILL_FULL;
                        state_nx_s = ST_DETECT;
                        if (hit_s) begin
                            match_nx_s = 1'b1;
                            count_nx_s = sat_inc(count_r);
                            state_nx_s = bus.continuous ? ST_DETECT : ST_DONE;
                        end else begin
                            match_nx_s = 1'b0;
                        end
                    end else begin
                        fill_nx_s = fill_r + FW'(1);
                    end
                end else begin
                    state_nx_s = ST_ARMED;
                end
            end
            ST_DETECT: begin
                if (bus.stop) begin
                    state_nx_s = ST_IDLE;
                end else if (bus.bit_valid) begin
                    window_nx_s = shifted_s;
                    if (hit_s) begin
                        match_nx_s = 1'b1;
                        count_nx_s = sat_inc(count_r);
                        state_nx_s = bus.continuous ? ST_DETECT : ST_DONE;
                    end else begin
                        match_nx_s = 1'b0;
                    end
                end else begin
                    state_nx_s = ST_DETECT;
                end
            end
            ST_DONE: begin
                if (bus.stop) begin
                    state_nx_s = ST_IDLE;
                end else if (bus.start) begin
                    state_nx_s  = ST_ARMED;
                    window_nx_s = {N{1'b0}};
                    fill_nx_s   = {FW{1'b0}};
                    count_nx_s  = {CNT_W{1'b0}};
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            pattern_r <= {N{1'b0}};
            window_r  <= {N{1'b0}};
            fill_r    <= {FW{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            match_r   <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            pattern_r <= pattern_nx_s;
            window_r  <= window_nx_s;
            fill_r    <= fill_nx_s;
            count_r   <= count_nx_s;
            match_r   <= match_nx_s;
            done_r    <= (state_nx_s == ST_DONE);
        end
    end

    assign bus.pattern     = pattern_r;
    assign bus.match       = match_r;
    assign bus.match_count = count_r;
    assign bus.state       = state_r;
    assign bus.done        = done_r;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: a default-width instance for the main
// scenarios and a CNT_W=2 instance for counter saturation.
module tb_seq_detect_ctrl;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    seq_detect_ctrl_if #(.N(10), .CNT_W(8)) bus1 ();
    seq_detect_ctrl_if #(.N(10), .CNT_W(2)) bus2 ();

    seq_detect_ctrl #(.N(10), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    seq_detect_ctrl #(.N(10), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed1(input logic b);
        bus1.bit_in    = b;
        bus1.bit_valid = 1'b1;
        tick();
        bus1.bit_valid = 1'b0;
    endtask

    task automatic feed2(input logic b);
        bus2.bit_in    = b;
        bus2.bit_valid = 1'b1;
        tick();
        bus2.bit_valid = 1'b0;
    endtask

    initial begin
        logic [9:0] p1;
        logic [9:0] p2;
        errors = 0;
        checks = 0;
        p1 = 10'b1011101101;
        p2 = 10'b1010101010;
        bus1.switches = 10'd0; bus1.load = 1'b0; bus1.start = 1'b0; bus1.stop = 1'b0;
        bus1.bit_in = 1'b0; bus1.bit_valid = 1'b0; bus1.continuous = 1'b0;
        bus2.switches = 10'd0; bus2.load = 1'b0; bus2.start = 1'b0; bus2.stop = 1'b0;
        bus2.bit_in = 1'b0; bus2.bit_valid = 1'b0; bus2.continuous = 1'b0;

        // Reset and load
        rst = 1'b0;
        tick();
        tick();
        check("rst_pattern", 32'(bus1.pattern), 32'h0);
        check("rst_state", 32'(bus1.state), 32'h0);
        check("rst_count", 32'(bus1.match_count), 32'h0);
        check("rst_match", 32'(bus1.match), 32'h0);
        check("rst_done", 32'(bus1.done), 32'h0);
        rst = 1'b1;
        bus1.switches = p1;
        bus1.load = 1'b1;
        tick();
        bus1.load = 1'b0;
        check("load_pattern", 32'(bus1.pattern), 32'h2ED);
        check("load_state", 32'(bus1.state), 32'h0);
        check("load_count", 32'(bus1.match_count), 32'h0);

        // Single hit, continuous=0
        bus1.continuous = 1'b0;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        check("start_state", 32'(bus1.state), 32'h1);
        for (int i = 9; i >= 1; i--) feed1(p1[i]);
        check("single_9_match", 32'(bus1.match), 32'h0);
        check("single_9_state", 32'(bus1.state), 32'h1);
        feed1(p1[0]);
        check("single_match", 32'(bus1.match), 32'h1);
        check("single_count", 32'(bus1.match_count), 32'h1);
        check("single_state", 32'(bus1.state), 32'h3);
        check("single_done", 32'(bus1.done), 32'h1);
        tick();
        check("single_pulse_end", 32'(bus1.match), 32'h0);
        for (int i = 9; i >= 0; i--) feed1(p1[i]);
        check("done_ignore_count", 32'(bus1.match_count), 32'h1);
        check("done_ignore_state", 32'(bus1.state), 32'h3);

        // Stop from DONE, then overlapping hits with continuous=1
        bus1.stop = 1'b1;
        tick();
        bus1.stop = 1'b0;
        check("stop_done_state", 32'(bus1.state), 32'h0);
        check("stop_done_count", 32'(bus1.match_count), 32'h1);
        bus1.switches = p2;
        bus1.load = 1'b1;
        tick();
        bus1.load = 1'b0;
        check("load2_pattern", 32'(bus1.pattern), 32'h2AA);
        bus1.continuous = 1'b1;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        check("start2_count", 32'(bus1.match_count), 32'h0);
        for (int i = 9; i >= 0; i--) feed1(p2[i]);
        check("ovl_match1", 32'(bus1.match), 32'h1);
        check("ovl_count1", 32'(bus1.match_count), 32'h1);
        check("ovl_state1", 32'(bus1.state), 32'h2);
        feed1(1'b1);
        check("ovl_between", 32'(bus1.match), 32'h0);
        feed1(1'b0);
        check("ovl_match2", 32'(bus1.match), 32'h1);
        check("ovl_count2", 32'(bus1.match_count), 32'h2);
        check("ovl_state2", 32'(bus1.state), 32'h2);

        // Stop and start together in DETECT: stop wins
        bus1.stop = 1'b1;
        bus1.start = 1'b1;
        tick();
        bus1.stop = 1'b0;
        bus1.start = 1'b0;
        check("stopstart_state", 32'(bus1.state), 32'h0);
        check("stopstart_count", 32'(bus1.match_count), 32'h2);

        // Gaps and early bits, plus load ignored while ARMED
        bus1.switches = p1;
        bus1.load = 1'b1;
        bus1.continuous = 1'b0;
        bus1.start = 1'b1;
        tick();
        bus1.load = 1'b0;
        bus1.start = 1'b0;
        check("loadstart_pattern", 32'(bus1.pattern), 32'h2ED);
        check("loadstart_state", 32'(bus1.state), 32'h1);
        for (int i = 9; i >= 1; i--) begin
            feed1(p1[i]);
            tick();
        end
        check("gap_9_match", 32'(bus1.match), 32'h0);
        check("gap_9_state", 32'(bus1.state), 32'h1);
        bus1.switches = 10'h3FF;
        bus1.load = 1'b1;
        tick();
        bus1.load = 1'b0;
        check("armed_load_ignored", 32'(bus1.pattern), 32'h2ED);
        feed1(p1[0]);
        check("gap_10_match", 32'(bus1.match), 32'h1);
        check("gap_10_state", 32'(bus1.state), 32'h3);
        check("gap_10_count", 32'(bus1.match_count), 32'h1);

        // Saturation on the CNT_W=2 instance with an all-zero pattern
        bus2.switches = 10'h000;
        bus2.load = 1'b1;
        bus2.continuous = 1'b1;
        tick();
        bus2.load = 1'b0;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        for (int i = 0; i < 9; i++) feed2(1'b0);
        check("sat_early_match", 32'(bus2.match), 32'h0);
        check("sat_early_count", 32'(bus2.match_count), 32'h0);
        feed2(1'b0);
        check("sat_10_count", 32'(bus2.match_count), 32'h1);
        feed2(1'b0);
        feed2(1'b0);
        check("sat_12_count", 32'(bus2.match_count), 32'h3);
        feed2(1'b0);
        check("sat_13_count", 32'(bus2.match_count), 32'h3);
        check("sat_13_match", 32'(bus2.match), 32'h1);
        check("sat_13_state", 32'(bus2.state), 32'h2);

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b0;
        #1;
        check("arst_pattern1", 32'(bus1.pattern), 32'h0);
        check("arst_state1", 32'(bus1.state), 32'h0);
        check("arst_count1", 32'(bus1.match_count), 32'h0);
        check("arst_done1", 32'(bus1.done), 32'h0);
        check("arst_match2", 32'(bus2.match), 32'h0);
        check("arst_count2", 32'(bus2.match_count), 32'h0);
        check("arst_state2", 32'(bus2.state), 32'h0);
        tick();
        rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
